// File: rtl/glyph_line_renderer_pkg.sv
// Shared constants and types for the glyph line renderer: glyph codes,
// FSM states and line geometry.
package glyph_line_renderer_pkg;

   localparam int GLYPH_COUNT = 8;
   localparam int GLYPH_WIDTH = 8;
   localparam int CODE_W      = 3;
   localparam int ROW_W       = 4;
   localparam int PTR_W       = $clog2(GLYPH_COUNT) + 1;

   localparam logic [CODE_W-1:0] GLYPH_F     = 3'd0;
   localparam logic [CODE_W-1:0] GLYPH_Q     = 3'd1;
   localparam logic [CODE_W-1:0] GLYPH_H     = 3'd2;
   localparam logic [CODE_W-1:0] GLYPH_X     = 3'd3;
   localparam logic [CODE_W-1:0] GLYPH_U     = 3'd4;
   localparam logic [CODE_W-1:0] GLYPH_BLANK = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // Codes above BLANK have no bitmap in the ROM, so they render as blank.
   function automatic logic [CODE_W-1:0] map_code(input logic [CODE_W-1:0] code);
      return (code > GLYPH_BLANK) ? GLYPH_BLANK : code;
   endfunction

endpackage

// File: rtl/glyph_line_renderer_if.sv
// Line request, character-ROM lookup and pixel-stream signals of the
// glyph line renderer.
interface glyph_line_renderer_if;
   logic        Start;
   logic [23:0] GlyphSel;
   logic [2:0]  Count;
   logic [3:0]  Row;
   logic [6:0]  Address;
   logic [7:0]  pxInRow;
   logic        PixelOut;
   logic        PixelValid;
   logic        Busy;
   logic        Done;

   modport master (
      output Start, GlyphSel, Count, Row, pxInRow,
      input  Address, PixelOut, PixelValid, Busy, Done
   );

   modport slave (
      input  Start, GlyphSel, Count, Row, pxInRow,
      output Address, PixelOut, PixelValid, Busy, Done
   );
endinterface

// File: rtl/glyph_line_renderer.sv
// Renders one scanline of up to eight glyphs as a serial, gap-free pixel
// stream, fetching each glyph row from an external character ROM.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for Start; outputs quiet, Address shows blank
// ST_LOAD  | one cycle: first glyph row captured from pxInRow
// ST_SHIFT | one pixel per cycle; next glyph reloaded on bit 7
module glyph_line_renderer
   import glyph_line_renderer_pkg::*;
(
   input  logic                  Clock,
   input  logic                  Resetn,
   glyph_line_renderer_if.slave  bus
);

   state_t                  state_q;
   logic [23:0]             gsel_q;
   logic [2:0]              cnt_q;
   logic [ROW_W-1:0]        row_q;
   logic [PTR_W-1:0]        ptr_q;
   logic [2:0]              bit_q;
   logic [GLYPH_WIDTH-1:0]  shreg_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    valid_q;

   logic                    pending;
   logic [CODE_W-1:0]       code_raw;

   // A glyph is pending while the pointer has not passed the last glyph of the line.
   assign pending = busy_q && (ptr_q <= {1'b0, cnt_q});

   always_comb begin
      code_raw = gsel_q[CODE_W-1:0];
      for (int i = 0; i < GLYPH_COUNT; i++) begin
         if (ptr_q[PTR_W-2:0] == i[PTR_W-2:0]) begin
            code_raw = gsel_q[i*CODE_W +: CODE_W];
         end
      end
   end

   assign bus.Address    = pending ? {map_code(code_raw), row_q} : {GLYPH_BLANK, row_q};
   assign bus.PixelOut   = valid_q & shreg_q[0];
   assign bus.PixelValid = valid_q;
   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         gsel_q  <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         ptr_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.Start) begin
                  gsel_q  <= bus.GlyphSel;
                  cnt_q   <= bus.Count;
                  row_q   <= bus.Row;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               shreg_q <= bus.pxInRow;
               ptr_q   <= ptr_q + 1'b1;
               bit_q   <= '0;
               valid_q <= 1'b1;
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if (pending) begin
                     shreg_q <= bus.pxInRow;
                     ptr_q   <= ptr_q + 1'b1;
                  end else begin
                     shreg_q <= '0;
                     ptr_q   <= '0;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  shreg_q <= shreg_q >> 1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
